fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 156 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-sequencing controller for a small datapath.
// Reads the instruction memory at ADDRESS = {4'b0, PC}, latches the word into
// IR, then either retires it locally (HALT, JUMP) or hands it to the datapath
// with a one-cycle EXEC_START. It waits for EXEC_DONE under a watchdog and
// steps or branches the PC. Any out-of-range PC update, a PC overrun or a
// watchdog expiry parks the machine in FAULT_ST. A faulting instruction is not
// counted as retired. HALT_ST and FAULT_ST are left only through RESET.
module fetch_sequencer #(
    parameter int MEM_DEPTH = 64,   // 1..64 words; the PC is 6 bits wide
    parameter int TIMEOUT   = 255   // WAIT cycles allowed without EXEC_DONE, >= 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [9:0]  INSTRUCTION,
    input  logic        EXEC_DONE,
    input  logic        BRANCH_TAKEN,
    input  logic [5:0]  BRANCH_TARGET,
    output logic [9:0]  ADDRESS,
    output logic [9:0]  IR,
    output logic        EXEC_START,
    output logic        BUSY,
    output logic        HALTED,
    output logic        FAULT,
    output logic [15:0] INSTR_COUNT
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, WAIT, HALT_ST, FAULT_ST
    } state_e;

    localparam logic [3:0] OP_JUMP   = 4'b1001;
    localparam int         WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [6:0] DEPTH_EXT = 7'(MEM_DEPTH);
    localparam logic [5:0] PC_LAST   = 6'(MEM_DEPTH - 1);

    state_e          state_q, state_d;
    logic [5:0]      pc_q, pc_d;
    logic [9:0]      ir_q, ir_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     cnt_inc;
    logic [WD_W-1:0] wd_q, wd_d;

    // A PC value is legal only if it addresses an existing memory word.
    function automatic logic in_range(input logic [5:0] addr);
        return {1'b0, addr} < DEPTH_EXT;
    endfunction

    // Retired-instruction count sticks at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // State, PC, IR, retired count and watchdog registers; all clear on RESET.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state logic: sequencing, decode, retirement and fault detection.
    // NOTE: every _d signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;

        case (state_q)
            IDLE: begin
                if (START) state_d = FETCH;
            end

            FETCH: begin
                ir_d    = INSTRUCTION;
                state_d = DECODE;
            end

            DECODE: begin
                if (ir_q == 10'b0) begin
                    cnt_d   = cnt_inc;
                    state_d = HALT_ST;
                end else if (ir_q[9:6] == OP_JUMP) begin
                    if (in_range(ir_q[5:0])) begin
                        pc_d    = ir_q[5:0];
                        cnt_d   = cnt_inc;
                        state_d = FETCH;
                    end else begin
                        state_d = FAULT_ST;
                    end
                end else begin
                    state_d = EXECUTE;
                end
            end

            EXECUTE: begin
                // EXECUTE is the only way into WAIT, so the watchdog is armed here.
                wd_d    = '0;
                state_d = WAIT;
            end

            WAIT: begin
                // EXEC_DONE takes priority over a watchdog expiry in the same cycle.
                if (EXEC_DONE) begin
                    if (BRANCH_TAKEN) begin
                        if (in_range(BRANCH_TARGET)) begin
                            pc_d    = BRANCH_TARGET;
                            cnt_d   = cnt_inc;
                            state_d = FETCH;
                        end else begin
                            state_d = FAULT_ST;
                        end
                    end else if (pc_q == PC_LAST) begin
                        state_d = FAULT_ST;
                    end else begin
                        pc_d    = pc_q + 6'd1;
                        cnt_d   = cnt_inc;
                        state_d = FETCH;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d = FAULT_ST;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end

            HALT_ST:  state_d = HALT_ST;
            FAULT_ST: state_d = FAULT_ST;
            default:  state_d = FAULT_ST;
        endcase
    end

    // Outputs decode directly from registered state, so they carry no input paths.
    assign ADDRESS     = {4'b0000, pc_q};
    assign IR          = ir_q;
    assign INSTR_COUNT = cnt_q;
    assign EXEC_START  = (state_q == EXECUTE);
    assign BUSY        = (state_q == FETCH) || (state_q == DECODE) ||
                         (state_q == EXECUTE) || (state_q == WAIT);
    assign HALTED      = (state_q == HALT_ST);
    assign FAULT       = (state_q == FAULT_ST);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios on the default
// configuration, boundary cases on a small MEM_DEPTH=16 / TIMEOUT=4 instance,
// and random programs checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        EXEC_DONE = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [5:0]  BRANCH_TARGET = '0;
    logic [9:0]  INSTRUCTION, INSTRUCTION_S;
    logic [9:0]  ADDRESS, IR, ADDRESS_S, IR_S;
    logic        EXEC_START, BUSY, HALTED, FAULT;
    logic        EXEC_START_S, BUSY_S, HALTED_S, FAULT_S;
    logic [15:0] INSTR_COUNT, INSTR_COUNT_S;

    logic [9:0]  mem   [64];
    logic [9:0]  mem_s [16];

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    localparam logic [9:0] W_HALT = 10'b0000000000;
    localparam logic [9:0] W_EXEC = 10'b0100001101;
    localparam int         DEPTH  = 64;

    typedef struct {
        int         delay;
        logic       taken;
        logic [5:0] tgt;
    } resp_t;

    typedef struct {
        int          edge_rel;
        logic [5:0]  pc;
        logic [15:0] cnt;
        logic        halted;
        logic        fault;
    } ev_t;

    assign INSTRUCTION   = mem[ADDRESS[5:0]];
    assign INSTRUCTION_S = mem_s[ADDRESS_S[3:0]];

    fetch_sequencer u_dut (
        .CLK(CLK), .RESET(RESET), .START(START), .INSTRUCTION(INSTRUCTION),
        .EXEC_DONE(EXEC_DONE), .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
        .ADDRESS(ADDRESS), .IR(IR), .EXEC_START(EXEC_START), .BUSY(BUSY),
        .HALTED(HALTED), .FAULT(FAULT), .INSTR_COUNT(INSTR_COUNT)
    );

    fetch_sequencer #(.MEM_DEPTH(16), .TIMEOUT(4)) u_small (
        .CLK(CLK), .RESET(RESET), .START(START), .INSTRUCTION(INSTRUCTION_S),
        .EXEC_DONE(EXEC_DONE), .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
        .ADDRESS(ADDRESS_S), .IR(IR_S), .EXEC_START(EXEC_START_S), .BUSY(BUSY_S),
        .HALTED(HALTED_S), .FAULT(FAULT_S), .INSTR_COUNT(INSTR_COUNT_S)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) edge_n <= edge_n + 1;

    function automatic logic [9:0] jump_to(input logic [5:0] t);
        return {4'b1001, t};
    endfunction

    task automatic fill(input logic [9:0] w);
        for (int i = 0; i < 64; i++) mem[i] = w;
        for (int i = 0; i < 16; i++) mem_s[i] = w;
    endtask

    task automatic reset_dut();
        RESET = 1'b1; START = 1'b0; EXEC_DONE = 1'b0;
        BRANCH_TAKEN = 1'b0; BRANCH_TARGET = '0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge inside the FETCH cycle,
    // with s = index of the edge that sampled START.
    task automatic start_pulse(output int s);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        s = edge_n;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({ADDRESS, IR, INSTR_COUNT, EXEC_START, BUSY, HALTED, FAULT} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0",
                     {ADDRESS, IR, INSTR_COUNT, EXEC_START, BUSY, HALTED, FAULT});
        end
        @(negedge CLK);
        RESET = 1'b0;
        step(3);
        n_tests++;
        if ({BUSY, HALTED, FAULT, EXEC_START} !== 4'b0000 || ADDRESS !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: got flags=%b addr=%0d, expected flags=0000 addr=0",
                     {BUSY, HALTED, FAULT, EXEC_START}, ADDRESS);
        end
    endtask

    task automatic test_halt();
        int s;
        fill(W_EXEC);
        mem[0] = W_HALT;
        reset_dut();
        start_pulse(s);
        n_tests++;
        if ({BUSY, HALTED, EXEC_START} !== 3'b100 || ADDRESS !== 10'd0) begin
            n_fail++;
            $display("FAIL halt_fetch: got busy/halted/exec=%b addr=%0d, expected 100 addr=0",
                     {BUSY, HALTED, EXEC_START}, ADDRESS);
        end
        step(1);
        n_tests++;
        if ({BUSY, HALTED, EXEC_START} !== 3'b100) begin
            n_fail++;
            $display("FAIL halt_decode: got busy/halted/exec=%b, expected 100", {BUSY, HALTED, EXEC_START});
        end
        step(1);
        n_tests++;
        if ({BUSY, HALTED, FAULT, EXEC_START} !== 4'b0100 || INSTR_COUNT !== 16'd1) begin
            n_fail++;
            $display("FAIL halt_state: got busy/halted/fault/exec=%b count=%0d, expected 0100 count=1",
                     {BUSY, HALTED, FAULT, EXEC_START}, INSTR_COUNT);
        end
        START = 1'b1;
        step(1);
        START = 1'b0;
        step(4);
        n_tests++;
        if ({BUSY, HALTED} !== 2'b01 || INSTR_COUNT !== 16'd1 || ADDRESS !== 10'd0) begin
            n_fail++;
            $display("FAIL halt_sticky: got busy/halted=%b count=%0d addr=%0d, expected 01 count=1 addr=0",
                     {BUSY, HALTED}, INSTR_COUNT, ADDRESS);
        end
    endtask

    task automatic test_exec_sequence();
        int s;
        fill(W_HALT);
        mem[0] = W_EXEC;
        reset_dut();
        start_pulse(s);
        step(2);
        n_tests++;
        if (EXEC_START !== 1'b1 || IR !== W_EXEC || ADDRESS !== 10'd0) begin
            n_fail++;
            $display("FAIL exec_start: got exec=%b ir=%b addr=%0d, expected exec=1 ir=%b addr=0",
                     EXEC_START, IR, ADDRESS, W_EXEC);
        end
        EXEC_DONE = 1'b1; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 6'h2A;
        step(1);
        n_tests++;
        if ({EXEC_START, BUSY} !== 2'b01 || ADDRESS !== 10'd0 || INSTR_COUNT !== 16'd0) begin
            n_fail++;
            $display("FAIL exec_wait: got exec/busy=%b addr=%0d count=%0d, expected 01 addr=0 count=0",
                     {EXEC_START, BUSY}, ADDRESS, INSTR_COUNT);
        end
        step(1);
        EXEC_DONE = 1'b0;
        n_tests++;
        if (ADDRESS !== 10'd1 || INSTR_COUNT !== 16'd1 || BUSY !== 1'b1) begin
            n_fail++;
            $display("FAIL exec_retire: got addr=%0d count=%0d busy=%b, expected addr=1 count=1 busy=1",
                     ADDRESS, INSTR_COUNT, BUSY);
        end
        step(2);
        n_tests++;
        if (HALTED !== 1'b1 || INSTR_COUNT !== 16'd2) begin
            n_fail++;
            $display("FAIL exec_then_halt: got halted=%b count=%0d, expected halted=1 count=2",
                     HALTED, INSTR_COUNT);
        end
    endtask

    task automatic test_jump();
        int s;
        fill(W_HALT);
        mem[0] = jump_to(6'd5);
        mem[5] = 10'b1001000010;
        reset_dut();
        start_pulse(s);
        step(2);
        n_tests++;
        if (ADDRESS !== 10'd5 || INSTR_COUNT !== 16'd1 || EXEC_START !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_first: got addr=%0d count=%0d exec=%b, expected addr=5 count=1 exec=0",
                     ADDRESS, INSTR_COUNT, EXEC_START);
        end
        step(1);
        n_tests++;
        if (IR !== 10'b1001000010 || EXEC_START !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_decode: got ir=%b exec=%b, expected ir=1001000010 exec=0", IR, EXEC_START);
        end
        step(1);
        n_tests++;
        if (ADDRESS !== 10'd2 || INSTR_COUNT !== 16'd2 || {BUSY, EXEC_START} !== 2'b10) begin
            n_fail++;
            $display("FAIL jump_second: got addr=%0d count=%0d busy/exec=%b, expected addr=2 count=2 busy/exec=10",
                     ADDRESS, INSTR_COUNT, {BUSY, EXEC_START});
        end
        step(2);
        n_tests++;
        if (HALTED !== 1'b1 || INSTR_COUNT !== 16'd3) begin
            n_fail++;
            $display("FAIL jump_halt: got halted=%b count=%0d, expected halted=1 count=3", HALTED, INSTR_COUNT);
        end
    endtask

    task automatic test_branch_timeout();
        int s;
        fill(W_HALT);
        mem[0] = W_EXEC;
        mem[6] = 10'b0011000001;
        reset_dut();
        start_pulse(s);
        step(2);
        EXEC_DONE = 1'b0;
        step(1);
        EXEC_DONE = 1'b1; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 6'd6;
        step(1);
        EXEC_DONE = 1'b0; BRANCH_TAKEN = 1'b0;
        n_tests++;
        if (ADDRESS !== 10'd6 || INSTR_COUNT !== 16'd1) begin
            n_fail++;
            $display("FAIL branch_taken: got addr=%0d count=%0d, expected addr=6 count=1", ADDRESS, INSTR_COUNT);
        end
        step(2);
        n_tests++;
        if (EXEC_START !== 1'b1 || ADDRESS !== 10'd6) begin
            n_fail++;
            $display("FAIL branch_exec: got exec=%b addr=%0d, expected exec=1 addr=6", EXEC_START, ADDRESS);
        end
        step(255);
        n_tests++;
        if ({FAULT, BUSY} !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_last_wait: got fault/busy=%b, expected 01", {FAULT, BUSY});
        end
        step(1);
        n_tests++;
        if ({FAULT, BUSY, HALTED} !== 3'b100 || ADDRESS !== 10'd6 || INSTR_COUNT !== 16'd1) begin
            n_fail++;
            $display("FAIL timeout_fault: got fault/busy/halted=%b addr=%0d count=%0d, expected 100 addr=6 count=1",
                     {FAULT, BUSY, HALTED}, ADDRESS, INSTR_COUNT);
        end
    endtask

    task automatic test_overrun();
        int s;
        fill(W_HALT);
        mem[0]  = jump_to(6'd63);
        mem[63] = 10'b0010101010;
        reset_dut();
        start_pulse(s);
        step(2);
        n_tests++;
        if (ADDRESS !== 10'd63) begin
            n_fail++;
            $display("FAIL overrun_fetch: got addr=%0d, expected 63", ADDRESS);
        end
        step(3);
        EXEC_DONE = 1'b1; BRANCH_TAKEN = 1'b0;
        step(1);
        EXEC_DONE = 1'b0;
        n_tests++;
        if ({FAULT, BUSY} !== 2'b10 || ADDRESS !== 10'd63) begin
            n_fail++;
            $display("FAIL overrun_fault: got fault/busy=%b addr=%0d, expected 10 addr=63", {FAULT, BUSY}, ADDRESS);
        end
        START = 1'b1;
        step(3);
        START = 1'b0;
        n_tests++;
        if (FAULT !== 1'b1 || ADDRESS !== 10'd63) begin
            n_fail++;
            $display("FAIL overrun_hold: got fault=%b addr=%0d, expected fault=1 addr=63", FAULT, ADDRESS);
        end
    endtask

    task automatic test_reset_in_wait();
        int s;
        fill(W_HALT);
        mem[0] = W_EXEC;
        reset_dut();
        start_pulse(s);
        step(2);
        EXEC_DONE = 1'b0;
        step(3);
        #2 RESET = 1'b1;
        #1;
        n_tests++;
        if ({ADDRESS, IR, INSTR_COUNT, EXEC_START, BUSY, HALTED, FAULT} !== 40'h0) begin
            n_fail++;
            $display("FAIL reset_async_in_wait: got %h, expected 0",
                     {ADDRESS, IR, INSTR_COUNT, EXEC_START, BUSY, HALTED, FAULT});
        end
        @(negedge CLK);
        RESET = 1'b0;
        start_pulse(s);
        step(2);
        n_tests++;
        if (EXEC_START !== 1'b1 || ADDRESS !== 10'd0 || INSTR_COUNT !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_exec: got exec=%b addr=%0d count=%0d, expected exec=1 addr=0 count=0",
                     EXEC_START, ADDRESS, INSTR_COUNT);
        end
        EXEC_DONE = 1'b1; BRANCH_TAKEN = 1'b0;
        step(2);
        EXEC_DONE = 1'b0;
        n_tests++;
        if (ADDRESS !== 10'd1 || INSTR_COUNT !== 16'd1) begin
            n_fail++;
            $display("FAIL restart_retire: got addr=%0d count=%0d, expected addr=1 count=1", ADDRESS, INSTR_COUNT);
        end
    endtask

    // One scenario on the MEM_DEPTH=16 / TIMEOUT=4 instance. done_at = WAIT
    // cycle (1-based) carrying EXEC_DONE, 0 = never. Checks at relative edge off.
    task automatic small_case(input string name, input logic [9:0] w0, input logic [9:0] w15,
                              input int done_at, input logic taken, input logic [5:0] tgt,
                              input int off, input logic [5:0] exp_addr, input logic exp_fault,
                              input logic chk_cnt, input logic [15:0] exp_cnt);
        int s;
        int k;
        k = -1;
        for (int i = 0; i < 16; i++) mem_s[i] = 10'b0001000011;
        mem_s[0]  = w0;
        mem_s[15] = w15;
        reset_dut();
        start_pulse(s);
        for (int c = 0; c <= off; c++) begin
            if (c == off - 1) begin
                n_tests++;
                if (FAULT_S !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_pre: got fault=%b, expected 0", name, FAULT_S);
                end
            end
            if (c == off) begin
                n_tests++;
                if ({FAULT_S, BUSY_S} !== {exp_fault, ~exp_fault} || ADDRESS_S !== {4'b0, exp_addr} ||
                    (chk_cnt && INSTR_COUNT_S !== exp_cnt)) begin
                    n_fail++;
                    $display("FAIL %s: got fault/busy=%b addr=%0d count=%0d, expected %b%b addr=%0d count=%0d",
                             name, {FAULT_S, BUSY_S}, ADDRESS_S, INSTR_COUNT_S,
                             exp_fault, ~exp_fault, exp_addr, exp_cnt);
                end
            end
            if (k >= 0) k++;
            else if (EXEC_START_S) k = 0;
            EXEC_DONE     = (k > 0 && k == done_at);
            BRANCH_TAKEN  = taken;
            BRANCH_TARGET = tgt;
            @(negedge CLK);
        end
        EXEC_DONE = 1'b0;
        BRANCH_TAKEN = 1'b0;
    endtask

    task automatic test_small_depth();
        small_case("small_jump_oob",     jump_to(6'd20), W_EXEC, 0, 1'b0, 6'd0,  2, 6'd0,  1'b1, 1'b1, 16'd0);
        small_case("small_done_at_limit", W_EXEC, W_EXEC,         4, 1'b0, 6'd0,  7, 6'd1,  1'b0, 1'b1, 16'd1);
        small_case("small_watchdog",      W_EXEC, W_EXEC,         0, 1'b0, 6'd0,  7, 6'd0,  1'b1, 1'b1, 16'd0);
        small_case("small_branch_oob",    W_EXEC, W_EXEC,         1, 1'b1, 6'd40, 4, 6'd0,  1'b1, 1'b1, 16'd0);
        small_case("small_overrun",  jump_to(6'd15), W_EXEC,      1, 1'b0, 6'd0,  6, 6'd15, 1'b1, 1'b0, 16'd0);
    endtask

    task automatic test_random(input int n_prog);
        resp_t      resp [32];
        resp_t      cur;
        ev_t        ev [$];
        logic [9:0] w;
        int         pc, cnt, t, ri, s, idx, ri_dut, wait_left, last;
        logic       flt;
        for (int p = 0; p < n_prog; p++) begin
            for (int i = 0; i < 64; i++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0) mem[i] = W_HALT;
                else if (r <= 2) mem[i] = jump_to(6'($urandom_range(0, 63)));
                else begin
                    w = 10'($urandom_range(1, 1023));
                    if (w[9:6] == 4'b1001) w[9] = 1'b0;
                    mem[i] = w;
                end
            end
            for (int j = 0; j < 32; j++) begin
                resp[j].delay = $urandom_range(1, 4);
                resp[j].taken = ($urandom_range(0, 3) == 0);
                resp[j].tgt   = 6'($urandom_range(0, 63));
            end

            // Instruction-level model: cycle cost per instruction, PC and count rules.
            ev.delete();
            pc = 0; cnt = 0; t = 0; ri = 0;
            for (int n = 0; n < 24; n++) begin
                w = mem[pc];
                flt = 1'b0;
                if (w == W_HALT) begin
                    t += 2;
                    if (cnt < 65535) cnt++;
                    ev.push_back('{t, 6'(pc), 16'(cnt), 1'b1, 1'b0});
                    break;
                end else if (w[9:6] == 4'b1001) begin
                    t += 2;
                    if (int'(w[5:0]) >= DEPTH) flt = 1'b1;
                    else pc = int'(w[5:0]);
                end else begin
                    t += 3 + resp[ri].delay;
                    if (resp[ri].taken) begin
                        if (int'(resp[ri].tgt) >= DEPTH) flt = 1'b1;
                        else pc = int'(resp[ri].tgt);
                    end else if (pc + 1 >= DEPTH) flt = 1'b1;
                    else pc = pc + 1;
                    ri++;
                end
                if (flt) begin
                    ev.push_back('{t, 6'(pc), 16'(cnt), 1'b0, 1'b1});
                    break;
                end
                if (cnt < 65535) cnt++;
                ev.push_back('{t, 6'(pc), 16'(cnt), 1'b0, 1'b0});
            end

            reset_dut();
            start_pulse(s);
            idx = 0; ri_dut = 0; wait_left = 0;
            last = ev[ev.size() - 1].edge_rel;
            for (int c = 0; c <= last; c++) begin
                if (idx < ev.size() && c == ev[idx].edge_rel) begin
                    n_tests++;
                    if (ADDRESS !== {4'b0, ev[idx].pc} || HALTED !== ev[idx].halted || FAULT !== ev[idx].fault ||
                        (!ev[idx].fault && INSTR_COUNT !== ev[idx].cnt)) begin
                        n_fail++;
                        $display("FAIL random_p%0d_ev%0d: got addr=%0d halted=%b fault=%b count=%0d, expected addr=%0d halted=%b fault=%b count=%0d",
                                 p, idx, ADDRESS, HALTED, FAULT, INSTR_COUNT,
                                 ev[idx].pc, ev[idx].halted, ev[idx].fault, ev[idx].cnt);
                    end
                    idx++;
                end
                if (wait_left > 0) begin
                    wait_left--;
                    EXEC_DONE     = (wait_left == 0);
                    BRANCH_TAKEN  = cur.taken;
                    BRANCH_TARGET = cur.tgt;
                end else if (EXEC_START && ri_dut < 32) begin
                    cur = resp[ri_dut];
                    ri_dut++;
                    wait_left     = cur.delay;
                    EXEC_DONE     = 1'($urandom_range(0, 1));
                    BRANCH_TAKEN  = 1'($urandom_range(0, 1));
                    BRANCH_TARGET = 6'($urandom_range(0, 63));
                end else begin
                    EXEC_DONE     = 1'($urandom_range(0, 1));
                    BRANCH_TAKEN  = 1'($urandom_range(0, 1));
                    BRANCH_TARGET = 6'($urandom_range(0, 63));
                end
                START = 1'($urandom_range(0, 1));
                @(negedge CLK);
            end
            START = 1'b0;
            EXEC_DONE = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_halt();
        test_exec_sequence();
        test_jump();
        test_branch_timeout();
        test_overrun();
        test_reset_in_wait();
        test_small_depth();
        test_random(8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
